cic_decim_n: RTL and testbench

- Parametrised N-stage CIC decimator for a 1-bit PDM microphone stream; produces one wide PCM sample per R accepted input bits.
- Integrators, decimation counter, a pipelined comb chain and an output register, with runtime-programmable decimation rate R and differential delay M.
- Sits between the PDM front-end (which supplies din/new_data) and the downstream FIR/compensation and buffering logic.
- Adds what the single-stage design lacked: configurable stage count and widths, correct clk_en/new_data qualification, multi-stage combs and start-up transient suppression.

---
 rtl/cic_pkg.sv | 46 ++++
 rtl/cic_decim_n_if.sv | 38 +++
 rtl/cic_comb_stage.sv | 85 ++++++++
 rtl/cic_decim_n.sv | 212 +++++++++++++++++++++
 tb/tb_cic_decim_n.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cic_pkg
//  Purpose  : Shared constants and helper functions for the cic_decim_n
//             CIC decimator: default parameter values, runtime clamping of the
//             decimation rate R and differential delay M, and the register
//             growth formula used to check OUT_W at elaboration.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cic_pkg;

    localparam int c_def_n_stages = 2;
    localparam int c_def_max_m    = 8;
    localparam int c_def_dec_w    = 16;
    localparam int c_def_out_w    = 32;
    localparam int c_def_r_max    = 256;

    // M: 0 behaves as 1, anything above the delay-line depth saturates.
    function automatic logic [7:0] clamp_m(input logic [7:0] m_raw,
                                           input int unsigned max_m);
        logic [7:0] m;
        if (m_raw == 8'd0) begin
            m = 8'd1;
        end else if (32'(m_raw) > max_m) begin
            m = 8'(max_m);
        end else begin
            m = m_raw;
        end
        return m;
    endfunction

    // R: 0 behaves as 1 (one output per accepted sample).
    function automatic logic [31:0] clamp_r(input logic [31:0] r_raw);
        return (r_raw == 32'd0) ? 32'd1 : r_raw;
    endfunction

    // Bits needed to hold the full-precision CIC gain (R*M)^N plus sign.
    function automatic int unsigned req_width(input int unsigned n,
                                              input int unsigned r,
                                              input int unsigned m);
        return n * $clog2(r * m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_decim_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim_n_if
//  Purpose  : Stream/config bundle between the PDM front-end, the CIC
//             decimator and the downstream PCM consumer.
//  Signals  : clk_en    global clock enable (all CIC state holds when low)
//             new_data  din valid
//             din       PDM bit
//             comb_num  differential delay M (8 bit)
//             dec_num   decimation rate R (DEC_W bit)
//             out       PCM sample (OUT_W bit, two's complement)
//             out_rdy   one-cycle pulse, out valid
//  Modports : master (front-end / consumer side), slave (decimator)
//  Revision : 1.0  initial release
// ============================================================================
interface cic_decim_n_if #(
    parameter int DEC_W = 16,
    parameter int OUT_W = 32
);
    logic             clk_en;
    logic             new_data;
    logic             din;
    logic [7:0]       comb_num;
    logic [DEC_W-1:0] dec_num;
    logic [OUT_W-1:0] out;
    logic             out_rdy;

    modport master (
        output clk_en, new_data, din, comb_num, dec_num,
        input  out, out_rdy
    );

    modport slave (
        input  clk_en, new_data, din, comb_num, dec_num,
        output out, out_rdy
    );
endinterface
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cic_comb_stage
//  Purpose  : One CIC comb section y = in - in[-M] with a MAX_M deep delay
//             line and a registered output. The delay line advances only on
//             this stage's own valid so M counts decimated samples.
//  Ports    : clk, rst (async, active low), clk_en (freeze when low)
//             clear      zero the delay line (M changed)
//             in/valid_in   sample from previous stage
//             M          current differential delay, already clamped 1..MAX_M
//             out/valid_out registered comb result
//  Revision : 1.0  initial release
// ============================================================================
module cic_comb_stage #(
    parameter int MAX_M = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             clear,
    input  logic [OUT_W-1:0] in,
    input  logic             valid_in,
    input  logic [7:0]       M,
    output logic [OUT_W-1:0] out,
    output logic             valid_out
);

    logic [OUT_W-1:0] dly_q [MAX_M];
    logic [OUT_W-1:0] dly_d [MAX_M];
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] tap;

    // Oldest sample of interest sits at index M-1.
    always_comb begin
        tap = dly_q[0];
        for (int i = 0; i < MAX_M; i++) begin
            if (M == 8'(i + 1)) begin
                tap = dly_q[i];
            end
        end
    end

    always_comb begin
        dly_d   = dly_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (clk_en) begin
            valid_d = valid_in;
            if (valid_in) begin
                out_d = in - tap;
            end
            if (clear) begin
                for (int i = 0; i < MAX_M; i++) begin
                    dly_d[i] = '0;
                end
            end else if (valid_in) begin
                dly_d[0] = in;
                for (int i = 1; i < MAX_M; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_M; i++) begin
                dly_q[i] <= '0;
            end
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dly_q   <= dly_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/cic_decim_n.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim_n
//  Purpose  : N-stage CIC decimator for a 1-bit PDM stream. N integrators run
//             at the accepted-sample rate, a decimation counter issues a tick
//             every R accepts, N pipelined comb stages run at the tick rate,
//             and the result is registered to out with an out_rdy pulse.
//             out_rdy is suppressed for the first N*M outputs after reset or
//             after a change of M (start-up transient).
//  Ports    : clk         system clock
//             rst         asynchronous, active-low reset
//             bus         cic_decim_n_if.slave (clk_en, new_data, din,
//                         comb_num, dec_num -> out, out_rdy)
//  Options  : CIC_BIPOLAR_EN  defined: din maps to +1/-1 (signed PCM around 0)
//                             undefined: din maps to 1/0 (unsigned magnitude)
//  Revision : 1.0  initial release
// ============================================================================
module cic_decim_n
    import cic_pkg::*;
#(
    parameter int N_STAGES = c_def_n_stages,
    parameter int MAX_M    = c_def_max_m,
    parameter int DEC_W    = c_def_dec_w,
    parameter int OUT_W    = c_def_out_w,
    parameter int R_MAX    = c_def_r_max
) (
    input  logic           clk,
    input  logic           rst,
    cic_decim_n_if.slave   bus
);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if ((N_STAGES < 1) || (N_STAGES > 6)) begin : g_chk_stages
        $error("cic_decim_n: N_STAGES must be in 1..6");
    end
    if ((MAX_M < 1) || (MAX_M > 255) || (DEC_W < 1) || (DEC_W > 32)) begin : g_chk_cfg
        $error("cic_decim_n: MAX_M must be 1..255 and DEC_W 1..32");
    end
    if (OUT_W < int'(req_width(N_STAGES, R_MAX, MAX_M))) begin : g_chk_width
        $error("cic_decim_n: OUT_W too small for (R_MAX*MAX_M)^N_STAGES growth");
    end

    // ------------------------------------------------------------------
    // Input qualification and runtime configuration
    // ------------------------------------------------------------------
    logic             accept;
    logic [OUT_W-1:0] x;
    logic [31:0]      r_eff;
    logic [7:0]       m_eff;
    logic [7:0]       m_q, m_d;
    logic             m_chg;

    assign accept = bus.clk_en && bus.new_data;
    assign r_eff  = clamp_r(32'(bus.dec_num));
    assign m_eff  = clamp_m(bus.comb_num, MAX_M);

`ifdef CIC_BIPOLAR_EN
    assign x = bus.din ? OUT_W'(1) : '1;
`else
    assign x = {{(OUT_W-1){1'b0}}, bus.din};
`endif

    // A new M invalidates the delay-line history: restart warm-up.
    assign m_chg = bus.clk_en && (m_eff != m_q);
    assign m_d   = bus.clk_en ? m_eff : m_q;

    // ------------------------------------------------------------------
    // Integrators (each stage adds the previous stage's old value)
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] integ_q [N_STAGES];
    logic [OUT_W-1:0] integ_d [N_STAGES];

    always_comb begin
        integ_d = integ_q;
        if (accept) begin
            integ_d[0] = integ_q[0] + x;
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimation counter. The >= compare makes a lowered R wrap on the
    // next accept instead of running all the way round.
    // ------------------------------------------------------------------
    logic [DEC_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (accept) begin
            if (32'(cnt_q) >= (r_eff - 32'd1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DEC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb chain input register: captures the last integrator including
    // the sample that produced the tick.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] comb_in_q, comb_in_d;
    logic             v0_q, v0_d;

    always_comb begin
        comb_in_d = comb_in_q;
        v0_d      = v0_q;
        if (bus.clk_en) begin
            v0_d = tick;
            if (tick) begin
                comb_in_d = integ_d[N_STAGES-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb chain
    // ------------------------------------------------------------------
    logic [N_STAGES:0][OUT_W-1:0] st_data;
    logic [N_STAGES:0]            st_vld;

    assign st_data[0] = comb_in_q;
    assign st_vld[0]  = v0_q;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .MAX_M (MAX_M),
            .OUT_W (OUT_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clk_en    (bus.clk_en),
            .clear     (m_chg),
            .in        (st_data[k]),
            .valid_in  (st_vld[k]),
            .M         (m_eff),
            .out       (st_data[k+1]),
            .valid_out (st_vld[k+1])
        );
    end

    // ------------------------------------------------------------------
    // Output register and warm-up suppression. out_rdy is forced low on
    // disabled cycles so it stays a single-cycle pulse during a stall.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] out_q, out_d;
    logic             rdy_q, rdy_d;
    logic [15:0]      wu_q, wu_d;
    logic [15:0]      wu_target;

    assign wu_target = 16'(N_STAGES) * {8'd0, m_eff};

    always_comb begin
        out_d = out_q;
        rdy_d = 1'b0;
        wu_d  = wu_q;
        if (bus.clk_en) begin
            if (st_vld[N_STAGES]) begin
                out_d = st_data[N_STAGES];
                if (wu_q < wu_target) begin
                    wu_d = wu_q + 16'd1;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            if (m_chg) begin
                wu_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q     <= '0;
            comb_in_q <= '0;
            v0_q      <= 1'b0;
            m_q       <= '0;
            out_q     <= '0;
            rdy_q     <= 1'b0;
            wu_q      <= '0;
        end else begin
            if (bus.clk_en) begin
                integ_q <= integ_d;
            end
            cnt_q     <= cnt_d;
            comb_in_q <= comb_in_d;
            v0_q      <= v0_d;
            m_q       <= m_d;
            out_q     <= out_d;
            rdy_q     <= rdy_d;
            wu_q      <= wu_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_rdy = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_decim_n
//  Purpose  : Self-checking bench for cic_decim_n (N_STAGES=2, MAX_M=8).
//             Expected PCM samples come from the closed-form CIC response:
//             after n accepts the second integrator holds
//             s(n) = sum_{u<n} (n-u)*x_u, and each output is the second
//             M-lag difference of s sampled every R accepts.
//  Options  : CIC_BIPOLAR_EN  selects +1/-1 input mapping in the model
//  Revision : 1.0  initial release
// ============================================================================
module tb_cic_decim_n;

    localparam int N     = 2;
    localparam int MAX_M = 8;
    localparam int DEC_W = 16;
    localparam int OUT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cic_decim_n_if #(.DEC_W(DEC_W), .OUT_W(OUT_W)) bus ();

    cic_decim_n #(
        .N_STAGES (N),
        .MAX_M    (MAX_M),
        .DEC_W    (DEC_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [OUT_W-1:0] got_q [$];
    int               xs    [$];

    // Collect every presented output sample.
    always @(negedge clk) begin
        if (rst && bus.out_rdy) begin
            got_q.push_back(bus.out);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int map_bit(input logic b);
`ifdef CIC_BIPOLAR_EN
        return b ? 1 : -1;
`else
        return b ? 1 : 0;
`endif
    endfunction

    // Second integrator value after n accepted samples.
    function automatic longint s_at(input int n);
        longint acc = 0;
        for (int u = 1; u < n; u++) begin
            acc += longint'(n - u) * longint'(xs[u-1]);
        end
        return acc;
    endfunction

    // pat: 0 all ones, 1 alternating 1/0, 2 random
    // stall: 0 continuous, 1 new_data alternate + clk_en low 5-cycle bursts,
    //        2 random clk_en/new_data
    task automatic run_seg(input string tag, input int r_raw, input int m_raw,
                           input int nacc, input int pat, input int stall);
        int r;
        int m;
        int acc;
        int guard;
        int frames;
        longint y;
        logic ce, nd, d;
        logic [OUT_W-1:0] exp_q [$];

        r = (r_raw == 0) ? 1 : r_raw;
        m = (m_raw == 0) ? 1 : ((m_raw > MAX_M) ? MAX_M : m_raw);
        acc = 0;
        guard = 0;

        bus.dec_num  = DEC_W'(r_raw);
        bus.comb_num = 8'(m_raw);
        bus.clk_en   = 1'b0;
        bus.new_data = 1'b0;
        bus.din      = 1'b0;
        xs.delete();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        got_q.delete();
        #1 rst = 1'b1;

        while ((acc < nacc) && (guard < 20000)) begin
            case (stall)
                0: begin ce = 1'b1; nd = 1'b1; end
                1: begin ce = ((guard % 12) >= 5); nd = ((guard % 2) == 0); end
                default: begin
                    ce = ($urandom_range(0, 3) != 0);
                    nd = ($urandom_range(0, 2) != 0);
                end
            endcase
            case (pat)
                0: d = 1'b1;
                1: d = ((acc % 2) == 0);
                default: d = 1'($urandom_range(0, 1));
            endcase
            bus.clk_en   = ce;
            bus.new_data = nd;
            bus.din      = d;
            if (ce && nd) begin
                xs.push_back(map_bit(d));
                acc++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.new_data = 1'b0;
        bus.clk_en   = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        check({tag, " accepts"}, 32'(acc), 32'(nacc));

        frames = nacc / r;
        for (int j = 1; j <= frames; j++) begin
            y = s_at(j * r) - 2 * s_at((j - m) * r) + s_at((j - 2 * m) * r);
            if (j > N * m) begin
                exp_q.push_back(OUT_W'(y));
            end
        end
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++) begin
            check($sformatf("%s out[%0d]", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int e;
        bus.clk_en   = 1'b0;
        bus.new_data = 1'b0;
        bus.din      = 1'b0;
        bus.dec_num  = '0;
        bus.comb_num = '0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset out", bus.out, '0);
        check("reset out_rdy", 32'(bus.out_rdy), 32'd0);

        // Latency: R=4, M=1, one accept per cycle from release. The third
        // frame (first unsuppressed) ticks on accept 12; out_rdy follows
        // N+1 enabled cycles later.
        bus.dec_num  = DEC_W'(4);
        bus.comb_num = 8'd1;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.clk_en   = 1'b1;
        bus.new_data = 1'b1;
        bus.din      = 1'b1;
        e = 0;
        while (e < 100) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (bus.out_rdy) break;
        end
        check("latency edges", 32'(e), 32'(3 * 4 + N + 1));
        check("latency value", bus.out, OUT_W'(16));
        @(posedge clk);
        #1;

        run_seg("ones_r8m1", 8, 1, 80, 0, 0);
        run_seg("alt_r8m1_stall", 8, 1, 96, 1, 1);
        run_seg("r0m0_ones", 0, 0, 20, 0, 0);
        run_seg("r4m9_rand", 4, 9, 160, 2, 2);
        run_seg("r5m3_rand", 5, 3, 150, 2, 2);

        // Asynchronous reset between clock edges, mid-frame
        run_seg("pre_rst", 8, 1, 44, 0, 0);
        check("pre_rst out", bus.out, OUT_W'(64));
        #3 rst = 1'b0;
        #1;
        check("async rst out", bus.out, '0);
        check("async rst out_rdy", 32'(bus.out_rdy), 32'd0);
        run_seg("post_rst", 8, 2, 96, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
